// File: rtl/node_pkg.sv
// Shared definitions for the node run sequencer.
//   node_state_e     : sequencer FSM states
//   OUTST_CNT_WIDTH  : width of the outstanding AXI transaction counter
//   OUTST_CNT_MAX    : saturation ceiling of that counter
package node_pkg;

    localparam int OUTST_CNT_WIDTH = 4;
    localparam logic [OUTST_CNT_WIDTH-1:0] OUTST_CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_STOP     = 3'd4
    } node_state_e;

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Outstanding AXI transaction counter for the core-side bridge.
// Each cycle the count moves by (aw_hs + ar_hs) - (b_hs + r_hs), with all
// four pulses netted together, and is clamped to [0, OUTST_CNT_MAX].
// Ports:
//   clk, res_n         : clock, asynchronous active-low reset
//   clr                : synchronous clear (wins over any handshakes)
//   aw_hs, ar_hs       : address handshakes (increment)
//   b_hs, r_hs         : response handshakes (decrement)
//   count              : registered outstanding count
module axi_outstanding_cnt
    import node_pkg::*;
(
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       clr,
    input  logic                       aw_hs,
    input  logic                       ar_hs,
    input  logic                       b_hs,
    input  logic                       r_hs,
    output logic [OUTST_CNT_WIDTH-1:0] count
);

    // Two spare bits hold the overshoot past the ceiling before clamping.
    localparam int SW = OUTST_CNT_WIDTH + 2;

    logic [OUTST_CNT_WIDTH-1:0] count_reg;
    logic [OUTST_CNT_WIDTH-1:0] count_next;
    logic [1:0]                 incr;
    logic [1:0]                 decr;
    logic [SW-1:0]              up_sum;
    logic [SW-1:0]              diff;

    always_comb begin
        incr   = {1'b0, aw_hs} + {1'b0, ar_hs};
        decr   = {1'b0, b_hs} + {1'b0, r_hs};
        up_sum = {2'b00, count_reg} + {{(SW-2){1'b0}}, incr};
        diff   = '0;
        count_next = count_reg;
        // Unsigned compare first so the subtraction can never wrap below 0.
        if (up_sum < {{(SW-2){1'b0}}, decr}) begin
            count_next = '0;
        end else begin
            diff = up_sum - {{(SW-2){1'b0}}, decr};
            if (diff > {2'b00, OUTST_CNT_MAX}) begin
                count_next = OUTST_CNT_MAX;
            end else begin
                count_next = diff[OUTST_CNT_WIDTH-1:0];
            end
        end
        if (clr) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/node_run_sequencer.sv
// Run sequencer for a gated compute core sharing an AXI bridge.
// Sequence: IDLE -> RST_HOLD (clock on, core in reset) -> RUN -> DRAIN
// (wait for outstanding AXI traffic, bounded) -> STOP (done pulse) -> IDLE.
// Ports:
//   clk, res_n            : clock, asynchronous active-low reset
//   start, start_offset   : task start request and its memory offset
//   fin, abort            : core finished / stop early
//   aw_hs, ar_hs, b_hs, r_hs : core-side AXI handshake pulses
//   clk_en, core_res_n    : clock-gater enable, core reset (active-low)
//   bus_sel               : 1 = core owns the bridge
//   axi_offset            : offset latched at start
//   busy, done, timeout   : status; timeout accompanies done on a forced stop
//   run_cycles            : cycles spent in RUN for the last/current task
// All outputs come straight from flops, so no input reaches an output
// combinationally.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module node_run_sequencer
    import node_pkg::*;
#(
    parameter int RESET_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int ADDR_WIDTH    = `AXI_ADDR_WIDTH,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_offset,
    input  logic                  fin,
    input  logic                  abort,
    input  logic                  aw_hs,
    input  logic                  ar_hs,
    input  logic                  b_hs,
    input  logic                  r_hs,
    output logic                  clk_en,
    output logic                  core_res_n,
    output logic                  bus_sel,
    output logic [ADDR_WIDTH-1:0] axi_offset,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  run_cycles
);

    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

    node_state_e                state_reg, state_next;
    logic [HOLD_W-1:0]          hold_cnt_reg, hold_cnt_next;
    logic [DRAIN_W-1:0]         drain_cnt_reg, drain_cnt_next;
    logic                       drain_expired;
    logic                       start_accept;
    logic [OUTST_CNT_WIDTH-1:0] outst_cnt;

    logic                  clk_en_reg;
    logic                  core_res_n_reg;
    logic                  bus_sel_reg;
    logic [ADDR_WIDTH-1:0] axi_offset_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  timeout_reg;
    logic [CNT_WIDTH-1:0]  run_cycles_reg;

    axi_outstanding_cnt u_outst_cnt (
        .clk   (clk),
        .res_n (res_n),
        .clr   (start_accept),
        .aw_hs (aw_hs),
        .ar_hs (ar_hs),
        .b_hs  (b_hs),
        .r_hs  (r_hs),
        .count (outst_cnt)
    );

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        drain_expired  = 1'b0;
        start_accept   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_accept  = 1'b1;
                    hold_cnt_next = '0;
                    state_next    = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                // Abort wins over hold completion; the core never ran, so
                // there is nothing to drain.
                if (abort) begin
                    state_next = ST_STOP;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (fin || abort) begin
                    drain_cnt_next = '0;
                    state_next     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Uses the registered count: a response landing this cycle
                // is seen one cycle later.
                if (outst_cnt == '0) begin
                    state_next = ST_STOP;
                end else if (drain_cnt_reg == DRAIN_LAST) begin
                    drain_expired = 1'b1;
                    state_next    = ST_STOP;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                end
            end
            ST_STOP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from state_next so they line up with state_reg.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg      <= ST_IDLE;
            hold_cnt_reg   <= '0;
            drain_cnt_reg  <= '0;
            clk_en_reg     <= 1'b0;
            core_res_n_reg <= 1'b0;
            bus_sel_reg    <= 1'b0;
            axi_offset_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            run_cycles_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            drain_cnt_reg  <= drain_cnt_next;
            clk_en_reg     <= (state_next == ST_RST_HOLD) || (state_next == ST_RUN) ||
                              (state_next == ST_DRAIN);
            bus_sel_reg    <= (state_next == ST_RST_HOLD) || (state_next == ST_RUN) ||
                              (state_next == ST_DRAIN);
            core_res_n_reg <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_STOP);
            if (start_accept) begin
                axi_offset_reg <= start_offset;
                run_cycles_reg <= '0;
                timeout_reg    <= 1'b0;
            end else begin
                if ((state_reg == ST_RUN) && (run_cycles_reg != '1)) begin
                    run_cycles_reg <= run_cycles_reg + CNT_WIDTH'(1);
                end
                if (drain_expired) begin
                    timeout_reg <= 1'b1;
                end
            end
        end
    end

    assign clk_en     = clk_en_reg;
    assign core_res_n = core_res_n_reg;
    assign bus_sel    = bus_sel_reg;
    assign axi_offset = axi_offset_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;
    assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_node_run_sequencer.sv
// Scoreboard bench for node_run_sequencer. Each task is described as a
// per-cycle schedule of inputs relative to the start edge; a reference model
// derives the expected phase lengths, run count and timeout from that
// schedule, pushes them to a queue, and a monitor compares on every done.
module tb_node_run_sequencer;

    localparam int LEN = 512;

    logic        clk;
    logic        res_n;
    logic        start;
    logic [31:0] start_offset;
    logic        fin, abort, aw_hs, ar_hs, b_hs, r_hs;
    logic        clk_en, core_res_n, bus_sel, busy, done, timeout;
    logic [31:0] axi_offset;
    logic [31:0] run_cycles;

    node_run_sequencer #(
        .RESET_CYCLES  (4),
        .DRAIN_TIMEOUT (255),
        .ADDR_WIDTH    (32),
        .CNT_WIDTH     (32)
    ) dut (
        .clk          (clk),
        .res_n        (res_n),
        .start        (start),
        .start_offset (start_offset),
        .fin          (fin),
        .abort        (abort),
        .aw_hs        (aw_hs),
        .ar_hs        (ar_hs),
        .b_hs         (b_hs),
        .r_hs         (r_hs),
        .clk_en       (clk_en),
        .core_res_n   (core_res_n),
        .bus_sel      (bus_sel),
        .axi_offset   (axi_offset),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .run_cycles   (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] off;
        int          hold;
        int          run;
        int          drain;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   npush = 0;
    int   npop  = 0;
    int   ntask = 0;

    // Schedule: index i is the i-th cycle after the start edge.
    logic sch_aw[LEN], sch_ar[LEN], sch_b[LEN], sch_r[LEN];
    logic sch_fin[LEN], sch_abort[LEN], sch_start[LEN];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < LEN; i++) begin
            sch_aw[i] = 1'b0; sch_ar[i] = 1'b0; sch_b[i] = 1'b0; sch_r[i] = 1'b0;
            sch_fin[i] = 1'b0; sch_abort[i] = 1'b0; sch_start[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; fin = 1'b0; abort = 1'b0;
        aw_hs = 1'b0; ar_hs = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
    endtask

    // Outstanding count after applying cycle i's handshakes, clamped to 0..15.
    function automatic int step(input int cnt, input int i);
        int v;
        v = cnt + int'(sch_aw[i]) + int'(sch_ar[i]) - int'(sch_b[i]) - int'(sch_r[i]);
        if (v < 0)  v = 0;
        if (v > 15) v = 15;
        return v;
    endfunction

    // Reference: cycles 0..3 are reset hold (abort stops, fin ignored), RUN
    // from cycle 4 until the first fin/abort, then DRAIN until the count is
    // zero or 255 drain cycles have passed. s = index of the STOP cycle.
    task automatic model(input logic [31:0] off, output exp_t e, output int s);
        int hc, t, cnt, d;
        e.off = off; e.hold = 4; e.run = 0; e.drain = 0; e.to = 1'b0; s = 0;
        hc = -1;
        for (int c = 0; c < 4; c++) if (sch_abort[c] && hc < 0) hc = c;
        if (hc >= 0) begin
            e.hold = hc + 1;
            s = hc + 1;
            return;
        end
        t = LEN - 300;
        for (int i = LEN - 301; i >= 4; i--) if (sch_fin[i] || sch_abort[i]) t = i;
        e.run = t - 3;
        cnt = 0;
        for (int i = 0; i <= t; i++) cnt = step(cnt, i);
        d = t + 1;
        for (int j = 0; j < 255; j++) begin
            if (cnt == 0) begin
                e.drain = j + 1;
                s = d + j + 1;
                return;
            end
            cnt = step(cnt, d + j);
        end
        e.drain = 255;
        e.to = 1'b1;
        s = d + 255;
    endtask

    task automatic do_task(input logic [31:0] off);
        exp_t e;
        int   s;
        model(off, e, s);
        // Stray starts while busy (including STOP) must all be dropped.
        for (int i = 0; i <= s; i++) sch_start[i] = ($urandom_range(0, 9) == 0);
        exp_q.push_back(e);
        npush++;
        start = 1'b1;
        start_offset = off;
        @(posedge clk); #1;
        start_offset = $urandom;
        for (int i = 0; i <= s + 1; i++) begin
            start = sch_start[i] && (i <= s);
            fin = sch_fin[i]; abort = sch_abort[i];
            aw_hs = sch_aw[i]; ar_hs = sch_ar[i]; b_hs = sch_b[i]; r_hs = sch_r[i];
            @(posedge clk); #1;
        end
        idle_inputs();
        for (int k = 0; k < 600 && npop < npush; k++) begin
            @(posedge clk); #1;
        end
        check("done_seen", npop, npush);
        // fin/abort/traffic while idle must not wake the sequencer.
        for (int k = 0; k < 3; k++) begin
            fin = 1'($urandom); abort = 1'($urandom);
            aw_hs = 1'($urandom); b_hs = 1'($urandom);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic gen_random();
        int n, f;
        clear_sched();
        n = $urandom_range(1, 60);
        f = 3 + n;
        for (int i = 0; i < LEN; i++) begin
            if (i <= f) begin
                sch_aw[i] = ($urandom_range(0, 3) == 0);
                sch_ar[i] = ($urandom_range(0, 3) == 0);
                sch_b[i]  = ($urandom_range(0, 3) == 0);
                sch_r[i]  = ($urandom_range(0, 3) == 0);
            end else begin
                sch_aw[i] = ($urandom_range(0, 15) == 0);
                sch_ar[i] = ($urandom_range(0, 15) == 0);
                sch_b[i]  = ($urandom_range(0, 2) == 0);
                sch_r[i]  = ($urandom_range(0, 2) == 0);
            end
        end
        case ($urandom_range(0, 2))
            0:       sch_fin[f] = 1'b1;
            1:       sch_abort[f] = 1'b1;
            default: begin sch_fin[f] = 1'b1; sch_abort[f] = 1'b1; end
        endcase
        if ($urandom_range(0, 7) == 0) sch_abort[$urandom_range(0, 3)] = 1'b1;
        if ($urandom_range(0, 3) == 0) sch_fin[$urandom_range(0, 3)] = 1'b1;
    endtask

    // Monitor: measures phase lengths from the outputs and checks on done.
    initial begin
        int   hold_seen, act_seen;
        logic chk_after;
        exp_t e;
        hold_seen = 0; act_seen = 0; chk_after = 1'b0;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                hold_seen = 0; act_seen = 0; chk_after = 1'b0;
            end else begin
                if (chk_after) begin
                    check("done_one_cycle", done, 0);
                    check("idle_after_stop", busy, 0);
                    chk_after = 1'b0;
                end
                if (clk_en && !core_res_n) hold_seen++;
                if (clk_en && core_res_n)  act_seen++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        npop++;
                        ntask++;
                        $display("task %0d: off=%08h hold=%0d run=%0d drain=%0d timeout=%0b",
                                 ntask, axi_offset, hold_seen, run_cycles,
                                 act_seen - int'(run_cycles), timeout);
                        check("hold_cycles", hold_seen, e.hold);
                        check("run_cycles", run_cycles, e.run);
                        check("drain_cycles", act_seen - int'(run_cycles), e.drain);
                        check("timeout", timeout, e.to);
                        check("axi_offset", axi_offset, e.off);
                        check("stop_bus", {clk_en, bus_sel, core_res_n, busy}, 1);
                    end
                    hold_seen = 0; act_seen = 0; chk_after = 1'b1;
                end
            end
        end
    end

    initial begin
        res_n = 1'b0;
        start_offset = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {clk_en, core_res_n, bus_sel, busy, done, timeout}, 0);
        check("rst_offset", axi_offset, 0);
        check("rst_run_cycles", run_cycles, 0);
        res_n = 1'b1;
        @(posedge clk); #1;

        // 100 RUN cycles, nothing outstanding.
        clear_sched(); sch_fin[103] = 1'b1;
        do_task(32'h0001_0000);
        // Two writes outstanding, responses 10 and 12 cycles after fin.
        clear_sched(); sch_aw[10] = 1'b1; sch_aw[11] = 1'b1; sch_fin[20] = 1'b1;
        sch_b[30] = 1'b1; sch_b[32] = 1'b1;
        do_task(32'h0002_0040);
        // One outstanding, never answered: forced stop.
        clear_sched(); sch_aw[10] = 1'b1; sch_fin[20] = 1'b1;
        do_task(32'h0003_0000);
        // Count 3, then aw+b together, then three responses.
        clear_sched();
        for (int i = 5; i <= 7; i++) sch_aw[i] = 1'b1;
        sch_aw[8] = 1'b1; sch_b[8] = 1'b1; sch_fin[12] = 1'b1;
        for (int i = 20; i <= 22; i++) sch_b[i] = 1'b1;
        do_task(32'h0004_1000);
        // 16 writes saturate at 15; 15 responses empty it.
        clear_sched();
        for (int i = 4; i <= 19; i++) sch_aw[i] = 1'b1;
        sch_fin[20] = 1'b1;
        for (int i = 22; i <= 36; i++) sch_b[i] = 1'b1;
        do_task(32'h0005_0000);
        // Abort in the second hold cycle; fin during hold is ignored.
        clear_sched(); sch_abort[1] = 1'b1; sch_fin[2] = 1'b1;
        do_task(32'h0006_0000);
        // Abort from RUN with a read in flight.
        clear_sched(); sch_fin[2] = 1'b1; sch_ar[10] = 1'b1; sch_r[25] = 1'b1;
        sch_abort[30] = 1'b1;
        do_task(32'h0007_0000);

        for (int k = 0; k < 20; k++) begin
            gen_random();
            do_task($urandom);
        end

        // Reset in the middle of RUN gates everything without a drain.
        start = 1'b1; start_offset = 32'hDEAD_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("run_clk_en", clk_en, 1);
        #2;
        res_n = 1'b0;
        #1;
        check("arst_clk_en", clk_en, 0);
        check("arst_bus_sel", bus_sel, 0);
        check("arst_busy", busy, 0);
        check("arst_run_cycles", run_cycles, 0);
        @(posedge clk); #1;
        res_n = 1'b1;
        @(posedge clk); #1;
        gen_random();
        do_task(32'h0008_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
